// File: rtl/inext_accumulator_bank.sv
// rtl/inext_accumulator_bank.sv - double-buffered per-neuron synaptic current store
module inext_accumulator_bank #(
    parameter int numneurons = 2,
    parameter int numwidth   = 16,
    parameter int tagbits    = 1
) (
    input  logic                clk,
    input  logic                asyn_reset_n,
    input  logic [tagbits-1:0]  acc_tag_in,
    input  logic                acc_wr_req,
    input  logic [numwidth:0]   acc_data_in,
    input  logic                spu_busy,
    output logic [numwidth:0]   i_next_out,
    input  logic [tagbits-1:0]  nu_rd_tag,
    output logic [numwidth:0]   nu_current_out,
    input  logic                swap_req,
    output logic                swap_done,
    output logic                acc_ready,
    output logic                active_bank,
    output logic                wr_dropped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [tagbits-1:0] LAST_TAG = tagbits'(numneurons - 1);

    state_t              state_q, state_d;
    logic [numwidth:0]   bank_q [2][numneurons];
    logic [tagbits-1:0]  cnt_q, cnt_d;
    logic                active_q, active_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;
    logic                dropped_q, dropped_d;
    logic [numwidth:0]   nu_q;
    logic                wr_accept;

    assign wr_accept      = acc_wr_req & acc_ready;
    assign i_next_out     = bank_q[active_q][acc_tag_in];
    assign nu_current_out = nu_q;
    assign swap_done      = done_q;
    assign active_bank    = active_q;
    assign wr_dropped     = dropped_q;

    // State register and control registers
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            nu_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
            nu_q      <= bank_q[~active_q][nu_rd_tag];
        end
    end

    // Bank storage: SPU write-back into the accumulate bank, zeroing during CLEAR
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int n = 0; n < numneurons; n++) begin
                    bank_q[b][n] <= '0;
                end
            end
        end else begin
            if (wr_accept) begin
                bank_q[active_q][acc_tag_in] <= acc_data_in;
            end
            if (state_q == CLEAR) begin
                bank_q[active_q][cnt_q] <= '0;
            end
        end
    end

    // Next-state logic, swap queueing, clear counter and bank toggle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pend_d    = pend_q | swap_req;
        done_d    = 1'b0;
        dropped_d = dropped_q | (acc_wr_req & ~acc_ready);
        case (state_q)
            IDLE: begin
                // Any pending request is consumed by leaving IDLE here
                pend_d = 1'b0;
                if (swap_req || pend_q) begin
                    state_d = spu_busy ? DRAIN : SWAP;
                end
            end
            DRAIN: begin
                if (!spu_busy) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                active_d = ~active_q;
                cnt_d    = '0;
                state_d  = CLEAR;
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_TAG) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        acc_ready = (state_q == IDLE) || (state_q == DRAIN);
    end

endmodule

// File: tb/tb_inext_accumulator_bank.sv
// tb/tb_inext_accumulator_bank.sv - self-checking bench for inext_accumulator_bank
module tb_inext_accumulator_bank;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int TB = 1;

    typedef logic [W:0]    cur_t;
    typedef logic [TB-1:0] tag_t;

    logic  clk = 1'b0;
    logic  asyn_reset_n;
    tag_t  acc_tag_in;
    logic  acc_wr_req;
    cur_t  acc_data_in;
    logic  spu_busy;
    cur_t  i_next_out;
    tag_t  nu_rd_tag;
    cur_t  nu_current_out;
    logic  swap_req;
    logic  swap_done;
    logic  acc_ready;
    logic  active_bank;
    logic  wr_dropped;

    int checks = 0;
    int errors = 0;

    // Reference model: two banks indexed by the model's notion of the accumulate bank
    cur_t ref_bank [2][N];
    logic ref_active;

    always #5 clk = ~clk;

    inext_accumulator_bank #(.numneurons(N), .numwidth(W), .tagbits(TB)) dut (
        .clk            (clk),
        .asyn_reset_n   (asyn_reset_n),
        .acc_tag_in     (acc_tag_in),
        .acc_wr_req     (acc_wr_req),
        .acc_data_in    (acc_data_in),
        .spu_busy       (spu_busy),
        .i_next_out     (i_next_out),
        .nu_rd_tag      (nu_rd_tag),
        .nu_current_out (nu_current_out),
        .swap_req       (swap_req),
        .swap_done      (swap_done),
        .acc_ready      (acc_ready),
        .active_bank    (active_bank),
        .wr_dropped     (wr_dropped)
    );

    task automatic check_v(input string tag, input cur_t obs, input cur_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic model_reset();
        ref_active = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int n = 0; n < N; n++)
                ref_bank[b][n] = '0;
    endtask

    task automatic model_swap();
        ref_active = ~ref_active;
        for (int n = 0; n < N; n++)
            ref_bank[ref_active][n] = '0;
    endtask

    task automatic write(input tag_t t, input cur_t d);
        acc_tag_in  = t;
        acc_data_in = d;
        acc_wr_req  = 1'b1;
        tick();
        acc_wr_req  = 1'b0;
        ref_bank[ref_active][t] = d;
    endtask

    task automatic check_inext(input string tag, input tag_t t);
        acc_tag_in = t;
        #1;
        check_v(tag, i_next_out, ref_bank[ref_active][t]);
    endtask

    task automatic check_nu(input string tag, input tag_t t);
        nu_rd_tag = t;
        tick();
        check_v(tag, nu_current_out, ref_bank[~ref_active][t]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cur_t rnd, rnd2;

        asyn_reset_n = 1'b0;
        acc_tag_in   = '0;
        acc_wr_req   = 1'b0;
        acc_data_in  = '0;
        spu_busy     = 1'b0;
        nu_rd_tag    = '0;
        swap_req     = 1'b0;
        model_reset();
        repeat (3) tick();

        // Reset state
        check_b("rst_active", active_bank, 1'b0);
        check_b("rst_ready", acc_ready, 1'b1);
        check_b("rst_done", swap_done, 1'b0);
        check_b("rst_dropped", wr_dropped, 1'b0);
        check_v("rst_nu", nu_current_out, '0);
        check_v("rst_inext", i_next_out, '0);
        asyn_reset_n = 1'b1;
        tick();

        // Write accumulate: random traffic, then the fixed pair
        for (int i = 0; i < 6; i++)
            write(tag_t'($urandom_range(0, N - 1)), cur_t'($urandom));
        write(1, 17'h00005);
        write(0, 17'h00003);
        check_inext("acc_inext_t0", 0);
        check_inext("acc_inext_t1", 1);
        check_v("acc_inext_t1_const", i_next_out, 17'h00005);
        check_nu("acc_frozen_t0", 0);
        check_nu("acc_frozen_t1", 1);

        // Idle swap with a same-cycle write that must land in the old bank
        rnd = cur_t'($urandom);
        acc_tag_in  = 0;
        acc_data_in = rnd;
        acc_wr_req  = 1'b1;
        swap_req    = 1'b1;
        tick();
        ref_bank[ref_active][0] = rnd;
        acc_wr_req = 1'b0;
        swap_req   = 1'b0;
        for (int k = 1; k <= N + 2; k++) begin
            sample();
            check_b("idle_swap_ready", acc_ready, (k <= N + 1) ? 1'b0 : 1'b1);
            check_b("idle_swap_active", active_bank, (k >= 2) ? ~ref_active : ref_active);
            check_b("idle_swap_done", swap_done, (k == N + 2) ? 1'b1 : 1'b0);
            tick();
        end
        model_swap();
        check_nu("idle_frozen_t0", 0);
        check_nu("idle_frozen_t1", 1);
        check_v("idle_frozen_t1_const", nu_current_out, 17'h00005);
        check_inext("idle_new_inext_t1", 1);

        // Drain: SPU busy around the request, writes still land in the old bank
        spu_busy = 1'b1;
        swap_req = 1'b1;
        tick();
        swap_req    = 1'b0;
        acc_tag_in  = 0;
        acc_data_in = 17'h1FFFF;
        acc_wr_req  = 1'b1;
        sample();
        check_b("drain_ready", acc_ready, 1'b1);
        tick();
        acc_wr_req = 1'b0;
        ref_bank[ref_active][0] = 17'h1FFFF;
        repeat (3) begin
            sample();
            check_b("drain_hold_ready", acc_ready, 1'b1);
            check_b("drain_hold_active", active_bank, ref_active);
            tick();
        end
        spu_busy    = 1'b0;
        rnd2        = cur_t'($urandom);
        acc_tag_in  = 1;
        acc_data_in = rnd2;
        acc_wr_req  = 1'b1;
        for (int k = 0; k <= N + 2; k++) begin
            sample();
            check_b("drain_exit_ready", acc_ready, (k >= 1 && k <= N + 1) ? 1'b0 : 1'b1);
            check_b("drain_exit_done", swap_done, (k == N + 2) ? 1'b1 : 1'b0);
            tick();
            if (k == 0) begin
                acc_wr_req = 1'b0;
                ref_bank[ref_active][1] = rnd2;
            end
        end
        model_swap();
        check_b("drain_active", active_bank, ref_active);
        check_nu("drain_frozen_t0", 0);
        check_v("drain_frozen_t0_const", nu_current_out, 17'h1FFFF);
        check_nu("drain_frozen_t1", 1);

        // Dropped write during CLEAR and a queued second swap
        write(0, cur_t'($urandom));
        write(1, cur_t'($urandom));
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        swap_req    = 1'b0;
        acc_tag_in  = 0;
        acc_data_in = cur_t'($urandom) | 17'h1;
        acc_wr_req  = 1'b1;
        sample();
        check_b("clear_ready", acc_ready, 1'b0);
        tick();
        acc_wr_req = 1'b0;
        sample();
        check_b("queue_first_done", swap_done, 1'b1);
        check_b("drop_flag", wr_dropped, 1'b1);
        model_swap();
        check_inext("drop_entry_t0", 0);
        tick();
        for (int k = 1; k <= N + 2; k++) begin
            sample();
            check_b("queue_ready", acc_ready, (k <= N + 1) ? 1'b0 : 1'b1);
            check_b("queue_active", active_bank, (k >= 2) ? ~ref_active : ref_active);
            check_b("queue_done", swap_done, (k == N + 2) ? 1'b1 : 1'b0);
            tick();
        end
        model_swap();
        check_b("queue_active_back", active_bank, 1'b0);
        write(1, cur_t'($urandom));
        write(0, cur_t'($urandom));
        check_b("drop_sticky", wr_dropped, 1'b1);
        check_nu("queue_frozen_t0", 0);
        check_nu("queue_frozen_t1", 1);

        // Reset asserted in the middle of CLEAR
        write(0, cur_t'($urandom) | 17'h1);
        write(1, cur_t'($urandom) | 17'h1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        sample();
        asyn_reset_n = 1'b0;
        #1;
        model_reset();
        check_b("midrst_active", active_bank, 1'b0);
        check_b("midrst_ready", acc_ready, 1'b1);
        check_b("midrst_dropped", wr_dropped, 1'b0);
        check_b("midrst_done", swap_done, 1'b0);
        check_v("midrst_nu", nu_current_out, '0);
        check_inext("midrst_inext_t0", 0);
        check_inext("midrst_inext_t1", 1);
        tick();
        asyn_reset_n = 1'b1;
        for (int k = 0; k <= N + 4; k++) begin
            sample();
            check_b("postrst_done", swap_done, 1'b0);
            check_b("postrst_active", active_bank, 1'b0);
            tick();
        end
        write(1, cur_t'($urandom));
        check_inext("postrst_inext_t1", 1);
        check_nu("postrst_frozen_t1", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inext_accumulator_bank.md
Name: inext_accumulator_bank

Overview:
- Double-buffered per-neuron synaptic current store, directly downstream of the synaptic processing unit.
- Supplies the SPU's i_next read operand and accepts its write-back.
- On a timestep boundary, freezes the accumulated bank for the neuron update stage and hands the SPU a freshly zeroed bank.

Parameters:
numneurons, 2, neuron count; must equal 2**tagbits
numwidth, 16, current values are numwidth+1 bits, two's-complement fixed point
tagbits, 1, neuron tag width

Ports:
clk  input  1  clock, rising edge
asyn_reset_n  input  1  asynchronous active-low reset
acc_tag_in  input  tagbits  SPU destination tag (SPU dst_tag_out)
acc_wr_req  input  1  SPU write strobe (SPU req_write_i_next)
acc_data_in  input  numwidth+1  SPU write data (SPU i_next_out)
spu_busy  input  1  SPU busy flag
i_next_out  output  numwidth+1  accumulate-bank entry at acc_tag_in, to SPU i_next_in
nu_rd_tag  input  tagbits  neuron update read address
nu_current_out  output  numwidth+1  frozen-bank entry at nu_rd_tag
swap_req  input  1  one-cycle timestep-end pulse
swap_done  output  1  one-cycle pulse when the new bank is cleared and ready
acc_ready  output  1  high when SPU writes are accepted
active_bank  output  1  index of the current accumulate bank
wr_dropped  output  1  sticky error flag

Behaviour:
- Storage: two register banks, A[0..1][0..numneurons-1], each numwidth+1 bits. The accumulate bank is A[active_bank]; the frozen bank is A[~active_bank].
- Reset (asyn_reset_n low, takes effect immediately):
  - all entries 0; active_bank=0; state=IDLE; acc_ready=1; swap_done=0; wr_dropped=0; nu_current_out=0; swap pending flag cleared.
  - Reset asserted mid-operation, including mid-CLEAR, aborts the operation with the same result.
- i_next_out: combinational read of A[active_bank][acc_tag_in]. No write bypass: a same-cycle write to the same tag is visible on the next cycle.
- Write: on a clk edge with acc_wr_req=1 and acc_ready=1, A[active_bank][acc_tag_in] <= acc_data_in. No arithmetic here; the SPU performs the add.
- nu_current_out: registered, 1-cycle latency, <= A[~active_bank][nu_rd_tag]. Updates every cycle in every state.
- FSM states: IDLE, DRAIN, SWAP, CLEAR.
  - IDLE: acc_ready=1. On swap_req or a pending swap, go to DRAIN if spu_busy=1, else go to SWAP.
  - DRAIN: acc_ready=1; SPU writes still land in the old accumulate bank. Go to SWAP on the first cycle with spu_busy=0.
  - SWAP (1 cycle): acc_ready=0. active_bank toggles on exit. Clear counter <= 0. Go to CLEAR.
  - CLEAR (numneurons cycles): acc_ready=0. Each cycle A[active_bank][cnt] <= 0 and cnt++. After the cycle with cnt=numneurons-1, go to IDLE; swap_done pulses high for exactly that IDLE entry cycle.
- swap_req in any state other than IDLE sets a pending flag; only one swap is queued. The flag is consumed on the next IDLE-to-DRAIN/SWAP transition.
- Simultaneous events:
  - A write accepted in the same cycle the IDLE/DRAIN-to-SWAP transition is taken lands in the pre-swap bank.
  - swap_req and acc_wr_req in the same IDLE cycle: the write is accepted.
- acc_wr_req while acc_ready=0: the write is discarded, wr_dropped <= 1 (sticky until reset), and the bank is unchanged.
- Swap latency: swap_req with spu_busy=0 gives swap_done exactly 2+numneurons cycles later.
- Tags wrap naturally because numneurons = 2**tagbits; no out-of-range address exists.

Test Plan:
- Write accumulate: reset; write 17'h00005 to tag 1, then 17'h00003 to tag 0 → i_next_out shows 0x00005 at tag 1 and 0x00003 at tag 0; frozen bank reads 0.
- Idle swap timing (numneurons=2): swap_req with spu_busy=0 at cycle t → acc_ready=0 for cycles t+1..t+3; active_bank=1 from t+2; swap_done pulses at t+4. nu_rd_tag=1 then gives nu_current_out=0x00005 one cycle later; i_next_out for tag 1 reads 0.
- Drain: spu_busy=1 for 5 cycles around swap_req, with a write of 0x1FFFF to tag 0 during DRAIN → write lands in the old bank; frozen tag 0 later reads 0x1FFFF; swap_done asserts 4 cycles after spu_busy falls.
- Dropped write: acc_wr_req during CLEAR → entry unchanged (0), wr_dropped=1 and remains 1 after further traffic.
- Queued swap: second swap_req during CLEAR → after swap_done, a second swap runs automatically and active_bank returns to 0.
- Reset mid-CLEAR: asyn_reset_n low → immediately all reads 0, active_bank=0, acc_ready=1, wr_dropped=0, and no swap_done after release.
